// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the instruction-phase controller: state encodings
// and default sizing for the wait timer and retired-instruction counter.
package phase_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

   localparam int DEF_MEM_TIMEOUT = 15;
   localparam int DEF_CNT_W       = 4;
   localparam int DEF_ICNT_W      = 16;

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait phase and flags the
// cycle on which one more miss would exceed the timeout.
module wait_timer #(
   parameter int CNT_W       = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic timeout
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign timeout = (count == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/phase_sequencer.sv
// Multicycle fetch/decode/execute/mem/writeback sequencer with memory
// stall handling, halt detection, timeout error and retired-instruction count.
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int ICNT_W      = DEF_ICNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              imem_ready,
   input  logic              dmem_ready,
   input  logic              is_load,
   input  logic              is_store,
   input  logic              reg_wr,
   input  logic              halt_instr,
   output logic              imem_req,
   output logic              ir_load,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic              reg_write_en,
   output logic              pc_en,
   output logic              busy,
   output logic              halted,
   output logic              timeout_err,
   output logic [2:0]        phase,
   output logic [ICNT_W-1:0] instr_count
);

   state_t state;
   logic   mem_op;
   logic   tmr_clr;
   logic   tmr_inc;
   logic   tmr_timeout;

   assign mem_op = is_load | is_store;

   // Handshake: req is held high every cycle of FETCH/MEM; the phase ends on
   // the first cycle ready is sampled high at the rising edge. No req/ready
   // pairing is remembered across phases.
   always_comb begin
      tmr_clr = 1'b0;
      tmr_inc = 1'b0;
      case (state)
         ST_IDLE:  tmr_clr = run;
         ST_WB:    tmr_clr = run;
         ST_EXEC:  tmr_clr = ~halt_instr & mem_op;
         ST_FETCH: tmr_inc = ~imem_ready;
         ST_MEM:   tmr_inc = ~dmem_ready;
         default: begin
            tmr_clr = 1'b0;
            tmr_inc = 1'b0;
         end
      endcase
   end

   wait_timer #(
      .CNT_W      (CNT_W),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .inc    (tmr_inc),
      .timeout(tmr_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (run) state <= ST_FETCH;
            ST_FETCH: begin
               if (imem_ready)       state <= ST_DECODE;
               else if (tmr_timeout) state <= ST_ERR;
            end
            ST_DECODE: state <= ST_EXEC;
            ST_EXEC: begin
               if (halt_instr)  state <= ST_HALT;
               else if (mem_op) state <= ST_MEM;
               else             state <= ST_WB;
            end
            ST_MEM: begin
               if (dmem_ready)       state <= ST_WB;
               else if (tmr_timeout) state <= ST_ERR;
            end
            ST_WB:     state <= run ? ST_FETCH : ST_IDLE;
            ST_HALT:   state <= ST_HALT;
            ST_ERR:    state <= ST_ERR;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count <= '0;
      end else if (state == ST_WB) begin
         instr_count <= instr_count + ICNT_W'(1);
      end
   end

   always_comb begin
      imem_req     = 1'b0;
      ir_load      = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_write_en = 1'b0;
      pc_en        = 1'b0;
      busy         = 1'b0;
      halted       = 1'b0;
      timeout_err  = 1'b0;
      case (state)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready;
            busy     = 1'b1;
         end
         ST_DECODE: busy = 1'b1;
         ST_EXEC:   busy = 1'b1;
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            busy     = 1'b1;
         end
         ST_WB: begin
            reg_write_en = reg_wr & ~is_store;
            pc_en        = 1'b1;
            busy         = 1'b1;
         end
         ST_HALT:   halted      = 1'b1;
         ST_ERR:    timeout_err = 1'b1;
         default:   busy        = 1'b0;
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: per-cycle vector table plus hand sequences for
// timeout, halt, asynchronous reset and counter wrap.
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic        reg_wr = 1'b0;
   logic        halt_instr = 1'b0;

   logic        imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en;
   logic        busy, halted, timeout_err;
   logic [2:0]  phase;
   logic [15:0] instr_count;

   logic        w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_reg_write_en, w_pc_en;
   logic        w_busy, w_halted, w_timeout_err;
   logic [2:0]  w_phase;
   logic [3:0]  w_instr_count;

   logic [11:0] obs;
   logic [11:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;

   // strobe groups: {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en, busy, halted, timeout_err}
   localparam logic [8:0] S_NONE    = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] S_FETCH_W = 9'b1_0_0_0_0_0_1_0_0;
   localparam logic [8:0] S_FETCH_R = 9'b1_1_0_0_0_0_1_0_0;
   localparam logic [8:0] S_BUSY    = 9'b0_0_0_0_0_0_1_0_0;
   localparam logic [8:0] S_MEM_RD  = 9'b0_0_1_0_0_0_1_0_0;
   localparam logic [8:0] S_MEM_WR  = 9'b0_0_1_1_0_0_1_0_0;
   localparam logic [8:0] S_WB_W    = 9'b0_0_0_0_1_1_1_0_0;
   localparam logic [8:0] S_WB_N    = 9'b0_0_0_0_0_1_1_0_0;
   localparam logic [8:0] S_HALT    = 9'b0_0_0_0_0_0_0_1_0;
   localparam logic [8:0] S_ERR     = 9'b0_0_0_0_0_0_0_0_1;

   typedef struct {
      logic [6:0] in;   // {run, imem_ready, dmem_ready, is_load, is_store, reg_wr, halt_instr}
      logic [2:0] ph;
      logic [8:0] s;
   } vec_t;

   vec_t vecs[30];

   phase_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .is_load(is_load), .is_store(is_store), .reg_wr(reg_wr), .halt_instr(halt_instr),
      .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .reg_write_en(reg_write_en), .pc_en(pc_en), .busy(busy), .halted(halted),
      .timeout_err(timeout_err), .phase(phase), .instr_count(instr_count)
   );

   phase_sequencer #(.ICNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .is_load(is_load), .is_store(is_store), .reg_wr(reg_wr), .halt_instr(halt_instr),
      .imem_req(w_imem_req), .ir_load(w_ir_load), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
      .reg_write_en(w_reg_write_en), .pc_en(w_pc_en), .busy(w_busy), .halted(w_halted),
      .timeout_err(w_timeout_err), .phase(w_phase), .instr_count(w_instr_count)
   );

   assign obs = {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en,
                 busy, halted, timeout_err, phase};

   // clock / reset
   always #5 clk = ~clk;

   task automatic set_in(input logic [6:0] in);
      {run, imem_ready, dmem_ready, is_load, is_store, reg_wr, halt_instr} = in;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(7'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   // driver + scoreboard: one clock cycle, entered and left at posedge+1
   task automatic cyc(input logic [6:0] in, input logic [2:0] ph, input logic [8:0] s,
                      input string nm);
      logic [11:0] e;
      set_in(in);
      exp_q.push_back({s, ph});
      #2;
      e = exp_q.pop_front();
      chk(nm, {20'b0, obs}, {20'b0, e});
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int i, input logic [6:0] in, input logic [2:0] ph, input logic [8:0] s);
      vecs[i].in = in;
      vecs[i].ph = ph;
      vecs[i].s  = s;
   endtask

   initial begin
      // ALU, load with 3 wait states, store with load+store, run dropped in MEM
      add(0,  7'b1100010, 3'd0, S_NONE);
      add(1,  7'b1100010, 3'd1, S_FETCH_R);
      add(2,  7'b1100010, 3'd2, S_BUSY);
      add(3,  7'b1100010, 3'd3, S_BUSY);
      add(4,  7'b1100010, 3'd5, S_WB_W);
      add(5,  7'b1000010, 3'd1, S_FETCH_W);
      add(6,  7'b1100010, 3'd1, S_FETCH_R);
      add(7,  7'b1001010, 3'd2, S_BUSY);
      add(8,  7'b1001010, 3'd3, S_BUSY);
      add(9,  7'b1001010, 3'd4, S_MEM_RD);
      add(10, 7'b1001010, 3'd4, S_MEM_RD);
      add(11, 7'b1001010, 3'd4, S_MEM_RD);
      add(12, 7'b1011010, 3'd4, S_MEM_RD);
      add(13, 7'b1001010, 3'd5, S_WB_W);
      add(14, 7'b1100010, 3'd1, S_FETCH_R);
      add(15, 7'b1001110, 3'd2, S_BUSY);
      add(16, 7'b1001110, 3'd3, S_BUSY);
      add(17, 7'b1011110, 3'd4, S_MEM_WR);
      add(18, 7'b0001110, 3'd5, S_WB_N);
      add(19, 7'b0000000, 3'd0, S_NONE);
      add(20, 7'b1000000, 3'd0, S_NONE);
      add(21, 7'b1100000, 3'd1, S_FETCH_R);
      add(22, 7'b1001000, 3'd2, S_BUSY);
      add(23, 7'b1001000, 3'd3, S_BUSY);
      add(24, 7'b0001000, 3'd4, S_MEM_RD);
      add(25, 7'b0011000, 3'd4, S_MEM_RD);
      add(26, 7'b0001000, 3'd5, S_WB_N);
      add(27, 7'b0000000, 3'd0, S_NONE);
      add(28, 7'b1000000, 3'd0, S_NONE);
      add(29, 7'b1100000, 3'd1, S_FETCH_R);

      // reset state, no clock edge seen yet
      #3;
      chk("reset_outputs", {20'b0, obs}, 32'd0);
      chk("reset_count", {16'b0, instr_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         if (i == 5) chk("count_after_first_wb", {16'b0, instr_count}, 32'd1);
         cyc(vecs[i].in, vecs[i].ph, vecs[i].s, $sformatf("vec%0d", i));
      end
      chk("count_after_table", {16'b0, instr_count}, 32'd4);

      // fetch timeout: exactly 15 not-ready cycles, then sticky ERR
      do_reset();
      cyc(7'b1000000, 3'd0, S_NONE, "to_idle");
      for (int i = 0; i < 15; i++) cyc(7'b1000000, 3'd1, S_FETCH_W, $sformatf("to_wait%0d", i));
      cyc(7'b1000000, 3'd7, S_ERR, "to_err");
      for (int i = 0; i < 3; i++) cyc({i[0], 6'b110000}, 3'd7, S_ERR, "to_err_held");

      // ready on the timeout cycle wins
      do_reset();
      cyc(7'b1000000, 3'd0, S_NONE, "tr_idle");
      for (int i = 0; i < 14; i++) cyc(7'b1000000, 3'd1, S_FETCH_W, $sformatf("tr_wait%0d", i));
      cyc(7'b1100000, 3'd1, S_FETCH_R, "tr_ready_last");
      cyc(7'b1000000, 3'd2, S_BUSY, "tr_decode");

      // halt with is_load set: no MEM, no count, run ignored
      do_reset();
      cyc(7'b1100010, 3'd0, S_NONE, "h_idle");
      cyc(7'b1100010, 3'd1, S_FETCH_R, "h_fetch0");
      cyc(7'b1100010, 3'd2, S_BUSY, "h_dec0");
      cyc(7'b1100010, 3'd3, S_BUSY, "h_exec0");
      cyc(7'b1100010, 3'd5, S_WB_W, "h_wb0");
      cyc(7'b1100000, 3'd1, S_FETCH_R, "h_fetch1");
      cyc(7'b1001001, 3'd2, S_BUSY, "h_dec1");
      cyc(7'b1001001, 3'd3, S_BUSY, "h_exec1");
      for (int i = 0; i < 4; i++) cyc({~i[0], 6'b011001}, 3'd6, S_HALT, "h_halted");
      chk("halt_count", {16'b0, instr_count}, 32'd1);

      // asynchronous reset between edges while waiting in MEM
      do_reset();
      cyc(7'b1100010, 3'd0, S_NONE, "r_idle");
      cyc(7'b1100010, 3'd1, S_FETCH_R, "r_fetch0");
      cyc(7'b1100010, 3'd2, S_BUSY, "r_dec0");
      cyc(7'b1100010, 3'd3, S_BUSY, "r_exec0");
      cyc(7'b1100010, 3'd5, S_WB_W, "r_wb0");
      cyc(7'b1100000, 3'd1, S_FETCH_R, "r_fetch1");
      cyc(7'b1001000, 3'd2, S_BUSY, "r_dec1");
      cyc(7'b1001000, 3'd3, S_BUSY, "r_exec1");
      cyc(7'b1001000, 3'd4, S_MEM_RD, "r_mem");
      set_in(7'b1001000);
      #2;
      chk("pre_rst_count", {16'b0, instr_count}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_outputs", {20'b0, obs}, 32'd0);
      chk("async_rst_count", {16'b0, instr_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 17 back-to-back ALU instructions: 4-bit counter wraps to 1
      set_in(7'b1100010);
      repeat (69) @(posedge clk);
      #1;
      chk("count_17", {16'b0, instr_count}, 32'd17);
      chk("count_wrap", {28'b0, w_instr_count}, 32'd1);
      chk("wrap_phase", {29'b0, phase}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multicycle instruction-phase controller for the core. It steps each instruction through fetch, decode, execute, optional memory and writeback. It stalls on variable-latency instruction and data memory handshakes and produces the PC, IR, register-file and data-memory enables. It also detects halt instructions and memory timeouts, and keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, consecutive not-ready cycles in a wait phase before entering ERR (legal range 2..2^CNT_W-1)
CNT_W, 4, width of the wait counter
ICNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level enable; sampled in IDLE and at the end of WB
imem_ready  in  1  instruction memory acknowledge
dmem_ready  in  1  data memory acknowledge
is_load  in  1  decoded load; valid from DECODE through WB
is_store  in  1  decoded store; valid from DECODE through WB
reg_wr  in  1  decoded instruction writes the register file
halt_instr  in  1  decoded halt
imem_req  out  1  instruction fetch request
ir_load  out  1  capture instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write
reg_write_en  out  1  register file write strobe
pc_en  out  1  PC advance strobe
busy  out  1  instruction in flight
halted  out  1  core halted
timeout_err  out  1  memory timeout, sticky
phase  out  3  current state encoding
instr_count  out  ICNT_W  retired instructions

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7. phase = state.
- Outputs are combinational from state and inputs. Only the state, wait counter and instr_count are registers.
- Reset (asynchronous, any time, including mid-wait):
  - state=IDLE, wait counter=0, instr_count=0.
  - All outputs read 0 immediately, with no clock edge required.
- IDLE: all strobes 0. run=1 -> FETCH, else stay.
- FETCH:
  - imem_req=1.
  - ir_load = imem_ready (same cycle).
  - imem_ready=1 -> DECODE; else wait.
- DECODE: one cycle, no strobes -> EXEC.
- EXEC: one cycle. Priority order:
  - halt_instr -> HALT.
  - else (is_load|is_store) -> MEM.
  - else -> WB.
- MEM:
  - dmem_req=1; dmem_we=is_store.
  - If is_load and is_store are both 1, the store wins (dmem_we=1).
  - dmem_ready=1 -> WB; else wait.
- WB: one cycle.
  - reg_write_en = reg_wr & ~is_store.
  - pc_en=1; instr_count increments (wraps at 2^ICNT_W).
  - Next state: run=1 -> FETCH, else IDLE. Deasserting run therefore always completes the current instruction.
- HALT:
  - halted=1, all strobes 0.
  - Held until reset; run is ignored.
  - A halt instruction does not pulse pc_en and does not count.
- ERR:
  - timeout_err=1, all strobes 0.
  - Held until reset.
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle with ready=0.
  - If ready=0 and counter==MEM_TIMEOUT-1, next state is ERR. ERR is therefore visible after exactly MEM_TIMEOUT consecutive not-ready cycles.
  - If ready=1 on the timeout cycle, ready wins and there is no error.
- busy = state in {FETCH, DECODE, EXEC, MEM, WB}.
- Latency with zero wait states:
  - ALU instruction: 4 cycles, FETCH to WB inclusive.
  - Load/store: 5 cycles.
  - Each ready=0 cycle adds 1.
- Back-to-back instructions: WB is followed directly by FETCH, with no bubble.

Decomposition:
- Shared package: state encodings (the 3-bit localparams), default MEM_TIMEOUT, ICNT_W.
- Sub-module wait_timer: CNT_W counter with clear, increment-enable and a timeout output (count==MEM_TIMEOUT-1). One instance serves both FETCH and MEM.

Test Plan:
- Reset, then run=1 with imem_ready=1 constantly and an ALU instruction with reg_wr=1 -> phase sequence 0,1,2,3,5,1. reg_write_en=1 and pc_en=1 only in WB. instr_count=1 after the first WB.
- Load with dmem_ready low 3 cycles -> MEM held 4 cycles, dmem_we=0 throughout, WB follows. Store with is_load=is_store=1 -> dmem_we=1 and reg_write_en=0 in WB.
- imem_ready held 0 with MEM_TIMEOUT=15 -> ERR entered after exactly 15 FETCH cycles, timeout_err=1 held. Repeat with ready=1 on the 15th cycle -> DECODE, no error.
- halt_instr=1 together with is_load=1 in EXEC -> HALT, halted=1, dmem_req never asserted, instr_count unchanged. Toggling run has no effect.
- run dropped during MEM -> instruction completes through WB, then IDLE with busy=0. Reasserting run -> FETCH next cycle.
- rst pulsed mid-MEM between clock edges -> outputs 0 and phase=0 immediately, instr_count=0. Run 2^16+1 ALU instructions -> instr_count wraps to 1.
